// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback -- final stage of the LC-3b pipeline.
//
// Holds the MEM/WB pipeline register, selects the register-file write value,
// drives the register-file write port (also used as the forwarding bus),
// keeps the architectural NZP condition codes and counts retired instructions.
//
// Ports
//   clk, reset_n        pipeline clock, synchronous active-low reset
//   address_in[15:0]    effective address from MEM (bit 0 = byte select)
//   data_in[15:0]       memory read data from MEM
//   cw_in[3:0]          control word {load_regfile, load_cc, wb_sel[1:0]}
//   new_pc_in[15:0]     link PC (PC+2)
//   result_in[15:0]     ALU / address result
//   ir_in[15:0]         instruction word (debug)
//   dr_in[2:0]          destination register
//   valid_in            MEM output holds a real instruction
//   stall_in            MEM is stalled this cycle (WB takes a bubble)
//   regfile_load        register-file write enable
//   regfile_dest[2:0]   register-file write address
//   regfile_data[15:0]  register-file write data / forwarding value
//   cc[2:0]             architectural {N,Z,P}
//   ir[15:0]            registered instruction word
//   valid               WB register holds a real instruction
//   retired[CNT_W-1:0]  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      address_in,
  input  logic [15:0]      data_in,
  input  logic [3:0]       cw_in,
  input  logic [15:0]      new_pc_in,
  input  logic [15:0]      result_in,
  input  logic [15:0]      ir_in,
  input  logic [2:0]       dr_in,
  input  logic             valid_in,
  input  logic             stall_in,
  output logic             regfile_load,
  output logic [2:0]       regfile_dest,
  output logic [15:0]      regfile_data,
  output logic [2:0]       cc,
  output logic [15:0]      ir,
  output logic             valid,
  output logic [CNT_W-1:0] retired
);

  // Control-word field positions.
  localparam int CW_LOAD_REGFILE = 3;
  localparam int CW_LOAD_CC      = 2;

  localparam logic [1:0] WB_RESULT = 2'b00;
  localparam logic [1:0] WB_DATA   = 2'b01;
  localparam logic [1:0] WB_BYTE   = 2'b10;
  localparam logic [1:0] WB_NEWPC  = 2'b11;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // MEM/WB register
  logic [15:0] address_q, data_q, new_pc_q, result_q, ir_q;
  logic [3:0]  cw_q;
  logic [2:0]  dr_q;
  logic        valid_q, valid_d;

  // Architectural state
  logic [2:0]       cc_q, cc_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Write-back datapath
  logic [15:0] data_sel;
  logic [7:0]  byte_sel;
  logic        wr_en, cc_en;

  // A stalled instruction is replaced by a bubble so it is written only once,
  // on the cycle MEM finally lets it through.
  assign valid_d = valid_in & ~stall_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      cw_q      <= '0;
      new_pc_q  <= '0;
      result_q  <= '0;
      ir_q      <= '0;
      dr_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      // Payload fields are don't-care for a bubble; loading them regardless
      // keeps the enable logic off the wide datapath.
      address_q <= address_in;
      data_q    <= data_in;
      cw_q      <= cw_in;
      new_pc_q  <= new_pc_in;
      result_q  <= result_in;
      ir_q      <= ir_in;
      dr_q      <= dr_in;
    end
  end

  // Byte loads are zero-extended; address bit 0 picks the high byte.
  assign byte_sel = address_q[0] ? data_q[15:8] : data_q[7:0];

  always_comb begin
    data_sel = result_q;
    unique case (cw_q[1:0])
      WB_RESULT: data_sel = result_q;
      WB_DATA:   data_sel = data_q;
      WB_BYTE:   data_sel = {8'h00, byte_sel};
      WB_NEWPC:  data_sel = new_pc_q;
      default:   data_sel = result_q;
    endcase
  end

  assign wr_en = valid_q & cw_q[CW_LOAD_REGFILE];
  assign cc_en = valid_q & cw_q[CW_LOAD_CC];

  // NZP is one-hot by construction: exactly one of the three cases holds.
  always_comb begin
    cc_d = cc_q;
    if (cc_en) begin
      if (data_sel[15])          cc_d = CC_N;
      else if (data_sel == 16'h0) cc_d = CC_Z;
      else                       cc_d = CC_P;
    end
  end

  // Counter wraps naturally at all-ones.
  assign retired_d = valid_q ? retired_q + 1'b1 : retired_q;

  // Reset wins over the in-flight instruction: no CC change, no count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cc_q      <= CC_Z;
      retired_q <= '0;
    end else begin
      cc_q      <= cc_d;
      retired_q <= retired_d;
    end
  end

  assign regfile_load = wr_en;
  assign regfile_dest = dr_q;
  assign regfile_data = data_sel;
  assign cc           = cc_q;
  assign ir           = ir_q;
  assign valid        = valid_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address_in, data_in, new_pc_in, result_in, ir_in;
  logic [3:0]  cw_in;
  logic [2:0]  dr_in;
  logic        valid_in, stall_in;
  logic        regfile_load;
  logic [2:0]  regfile_dest;
  logic [15:0] regfile_data;
  logic [2:0]  cc;
  logic [15:0] ir;
  logic        valid;
  logic [15:0] retired;

  always #5 clk = ~clk;

  writeback #(.CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .address_in(address_in), .data_in(data_in), .cw_in(cw_in),
    .new_pc_in(new_pc_in), .result_in(result_in), .ir_in(ir_in),
    .dr_in(dr_in), .valid_in(valid_in), .stall_in(stall_in),
    .regfile_load(regfile_load), .regfile_dest(regfile_dest),
    .regfile_data(regfile_data), .cc(cc), .ir(ir), .valid(valid),
    .retired(retired)
  );

  typedef struct {
    logic        v, lr, lc;
    logic [1:0]  sel;
    logic [15:0] addr, data, npc, res, ir;
    logic [2:0]  dr;
  } ins_t;

  typedef struct {
    logic        stall;
    ins_t        in;
    logic        e_load;
    logic [2:0]  e_dest;
    logic [15:0] e_data;
    logic        chk_data;
    logic [2:0]  e_cc;
    logic [15:0] e_ret;
  } vec_t;

  // Reference model: contents of the WB slot plus architectural state.
  ins_t        wb_m;
  logic [2:0]  m_cc;
  int          m_ret;
  int          n_checks = 0;
  int          n_err = 0;

  function automatic ins_t mk(logic v, logic lr, logic lc, logic [1:0] sel,
                              logic [15:0] addr, logic [15:0] data,
                              logic [15:0] npc, logic [15:0] res, logic [2:0] dr);
    ins_t x;
    x.v = v; x.lr = lr; x.lc = lc; x.sel = sel; x.addr = addr; x.data = data;
    x.npc = npc; x.res = res; x.dr = dr; x.ir = 16'h0;
    return x;
  endfunction

  function automatic int wval(ins_t m);
    case (m.sel)
      2'd0:    return int'(m.res);
      2'd1:    return int'(m.data);
      2'd2:    return (int'(m.data) / ((m.addr % 2 == 1) ? 256 : 1)) % 256;
      default: return int'(m.npc);
    endcase
  endfunction

  function automatic logic [2:0] cc_of(int v);
    if (v >= 32768) return 3'b100;
    if (v == 0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic drive(ins_t x, logic stall);
    valid_in   = x.v;
    cw_in      = {x.lr, x.lc, x.sel};
    address_in = x.addr;
    data_in    = x.data;
    new_pc_in  = x.npc;
    result_in  = x.res;
    ir_in      = x.ir;
    dr_in      = x.dr;
    stall_in   = stall;
  endtask

  // Advance the model for the coming edge, then the DUT; sample 1 unit later.
  task automatic tick();
    if (!reset_n) begin
      m_cc = 3'b010; m_ret = 0; wb_m.v = 1'b0;
    end else begin
      if (wb_m.v) begin
        m_ret = (m_ret + 1) % 65536;
        if (wb_m.lc) m_cc = cc_of(wval(wb_m));
      end
      wb_m.v = valid_in & ~stall_in;
      wb_m.lr = cw_in[3]; wb_m.lc = cw_in[2]; wb_m.sel = cw_in[1:0];
      wb_m.addr = address_in; wb_m.data = data_in; wb_m.npc = new_pc_in;
      wb_m.res = result_in; wb_m.ir = ir_in; wb_m.dr = dr_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".valid"}, valid, wb_m.v);
    chk({tag, ".load"}, regfile_load, wb_m.v & wb_m.lr);
    chk({tag, ".cc"}, cc, m_cc);
    chk({tag, ".retired"}, retired, m_ret);
    if (wb_m.v) begin
      chk({tag, ".dest"}, regfile_dest, wb_m.dr);
      chk({tag, ".data"}, regfile_data, wval(wb_m));
      chk({tag, ".ir"}, ir, wb_m.ir);
    end
  endtask

  vec_t vt[7];
  ins_t bub, x;
  logic st;

  initial begin
    wb_m = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_cc = 3'b010; m_ret = 0;
    bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset ----------------
    drive(bub, 1'b0);
    reset_n = 1'b0;
    tick(); tick();
    chk("rst.valid", valid, 0);
    chk("rst.load", regfile_load, 0);
    chk("rst.cc", cc, 3'b010);
    chk("rst.retired", retired, 0);
    reset_n = 1'b1;

    // ---------------- table ----------------
    // cc/retired columns are the values visible right after the row's edge.
    vt[0] = '{1'b0, mk(1,1,1,2'b00,16'h0,16'h0,16'h0,16'h8001,3'd3), 1, 3'd3, 16'h8001, 1, 3'b010, 16'd0};
    vt[1] = '{1'b0, mk(1,1,1,2'b10,16'h3001,16'hAB12,16'h0,16'h0,3'd1), 1, 3'd1, 16'h00AB, 1, 3'b100, 16'd1};
    vt[2] = '{1'b0, mk(1,1,1,2'b10,16'h3000,16'hAB12,16'h0,16'h0,3'd1), 1, 3'd1, 16'h0012, 1, 3'b001, 16'd2};
    vt[3] = '{1'b0, mk(1,1,0,2'b11,16'h0,16'h0,16'h1002,16'h0,3'd7), 1, 3'd7, 16'h1002, 1, 3'b001, 16'd3};
    vt[4] = '{1'b0, mk(0,1,1,2'b00,16'h0,16'h0,16'h0,16'h8000,3'd2), 0, 3'd0, 16'h0, 0, 3'b001, 16'd4};
    vt[5] = '{1'b0, mk(1,0,1,2'b00,16'h0,16'h0,16'h0,16'h0000,3'd4), 0, 3'd4, 16'h0000, 1, 3'b001, 16'd4};
    vt[6] = '{1'b1, mk(1,1,1,2'b00,16'h0,16'h0,16'h0,16'h8000,3'd2), 0, 3'd0, 16'h0, 0, 3'b010, 16'd5};
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].in, vt[i].stall);
      tick();
      chk($sformatf("tbl%0d.load", i), regfile_load, vt[i].e_load);
      if (vt[i].chk_data) begin
        chk($sformatf("tbl%0d.dest", i), regfile_dest, vt[i].e_dest);
        chk($sformatf("tbl%0d.data", i), regfile_data, vt[i].e_data);
      end
      chk($sformatf("tbl%0d.cc", i), cc, vt[i].e_cc);
      chk($sformatf("tbl%0d.retired", i), retired, vt[i].e_ret);
      check_model($sformatf("tbl%0d", i));
    end

    // ---------------- stall: one write after stall drops ----------------
    drive(mk(1,1,1,2'b00,16'h0,16'h0,16'h0,16'h8001,3'd2), 1'b0);
    tick();
    drive(mk(1,1,1,2'b01,16'h0,16'h0000,16'h0,16'h0,3'd6), 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d.load", i), regfile_load, 0);
      chk($sformatf("stall%0d.cc", i), cc, 3'b100);
      chk($sformatf("stall%0d.retired", i), retired, 6);
    end
    stall_in = 1'b0;
    tick();
    chk("unstall.load", regfile_load, 1);
    chk("unstall.dest", regfile_dest, 6);
    chk("unstall.data", regfile_data, 16'h0000);
    drive(bub, 1'b0);
    tick();
    chk("after.load", regfile_load, 0);
    chk("after.cc", cc, 3'b010);
    chk("after.retired", retired, 7);

    // ---------------- random vs model ----------------
    for (int i = 0; i < 400; i++) begin
      x = mk($urandom_range(0,3) != 0, $urandom_range(0,1), $urandom_range(0,1),
             2'($urandom_range(0,3)), 16'($urandom), 16'($urandom),
             16'($urandom), ($urandom_range(0,7) == 0) ? 16'h0 : 16'($urandom),
             3'($urandom_range(0,7)));
      x.ir = 16'($urandom);
      st = ($urandom_range(0,4) == 0);
      drive(x, st);
      reset_n = ($urandom_range(0,49) != 0);
      tick();
      check_model("rnd");
    end
    reset_n = 1'b1;

    // ---------------- wrap and reset mid-stream ----------------
    drive(bub, 1'b0);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    drive(mk(1,0,0,2'b00,16'h0,16'h0,16'h0,16'h1,3'd0), 1'b0);
    repeat (65535) tick();
    drive(bub, 1'b0);
    tick();
    chk("wrap.ffff", retired, 16'hFFFF);
    drive(mk(1,0,0,2'b00,16'h0,16'h0,16'h0,16'h1,3'd0), 1'b0);
    tick();
    drive(bub, 1'b0);
    tick();
    chk("wrap.zero", retired, 16'h0000);
    drive(mk(1,1,1,2'b00,16'h0,16'h0,16'h0,16'h8000,3'd5), 1'b0);
    tick();
    chk("midrst.pre_load", regfile_load, 1);
    drive(bub, 1'b0);
    reset_n = 1'b0;
    tick();
    chk("midrst.load", regfile_load, 0);
    chk("midrst.valid", valid, 0);
    chk("midrst.cc", cc, 3'b010);
    chk("midrst.retired", retired, 0);
    check_model("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final stage of the LC-3b pipeline, directly downstream of the memory stage. Holds the MEM/WB pipeline register, selects the register-file write value (ALU result, loaded word, zero-extended loaded byte, or link PC), drives the register-file write port and forwarding bus, maintains the architectural NZP condition-code register, and counts retired instructions. One instruction retires per cycle at most; each valid instruction is written back exactly once.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- address_in  in  16  effective address from memory stage (bit 0 selects the byte).
- data_in  in  16  memory read data from memory stage.
- cw_in  in  lc3b_control_word  control word; fields used: load_regfile, load_cc, wb_sel[1:0].
- new_pc_in  in  16  link PC (PC+2 of the instruction).
- result_in  in  16  ALU/address result.
- ir_in  in  16  instruction word (carried for debug only).
- dr_in  in  3  destination register number (low 3 bits of the memory stage's dr).
- valid_in  in  1  memory-stage output holds a real instruction.
- stall_in  in  1  memory stage is stalled this cycle.
- regfile_load  out  1  register-file write enable.
- regfile_dest  out  3  register-file write address.
- regfile_data  out  16  register-file write data; also the forwarding value.
- cc  out  3  architectural NZP register {N,Z,P}.
- ir  out  16  registered instruction word.
- valid  out  1  WB register holds a real instruction.
- retired  out  CNT_W  retired-instruction count.

## Operation
- WB register fields: address, data, cw, new_pc, result, ir, dr, valid. Loaded every rising edge.
- If stall_in=1: register loads a bubble (valid<=0, other fields don't-care), so a stalled instruction is never written twice. If stall_in=0: register loads all *_in fields, valid<=valid_in.
- Write-data select from registered fields by cw.wb_sel: 00 result; 01 data; 10 byte = address[0] ? {8'h00,data[15:8]} : {8'h00,data[7:0]}; 11 new_pc.
- regfile_load = valid & cw.load_regfile; regfile_dest = dr; regfile_data = selected value. All combinational from the WB register.
- CC update on edge when valid & cw.load_cc: N=data_sel[15]; Z=(data_sel==0); P=~N&~Z. Exactly one bit set at all times.
- retired increments by 1 on each edge where valid=1; wraps modulo 2^CNT_W.
- ir output = registered ir.

## Timing
- Latency: instruction presented at input in cycle t (stall_in=0) appears in WB register in cycle t+1; regfile_load/data asserted during t+1; register file and cc capture at end of t+1 (edge t+2).
- Reset (reset_n=0 at an edge): valid<=0, cc<=3'b010, retired<=0; regfile_load=0 the following cycle. Reset mid-stream drops the in-flight WB instruction (no write, no count, no CC change).
- Back-to-back instructions: one per cycle, no bubbles inserted by this block.
- stall_in=1 for N cycles: N consecutive bubbles; valid=0, no writes, counter and cc hold.
- valid_in=0 with stall_in=0: bubble; identical to stall case.
- load_regfile=0 with load_cc=1 (e.g. non-writing CC op): CC updates, no register write.
- Counter at all-ones with valid=1: wraps to 0.

## Test plan
- Reset: hold reset_n=0 two cycles -> valid=0, regfile_load=0, cc=3'b010, retired=0.
- ALU op: cw{load_regfile=1,load_cc=1,wb_sel=00}, result_in=16'h8001, dr_in=3 -> next cycle regfile_load=1, dest=3, data=16'h8001; cc=3'b100 one cycle later; retired=1.
- LDB: wb_sel=10, data_in=16'hAB12, address_in=16'h3001, load_cc=1 -> data=16'h00AB, cc=3'b001; repeat with address_in=16'h3000 -> 16'h0012.
- JSR link: wb_sel=11, new_pc_in=16'h1002, dr_in=7, load_cc=0 -> dest=7, data=16'h1002, cc unchanged.
- Stall: present LDR (wb_sel=01, data_in=0, load_cc=1) with stall_in=1 for 3 cycles then 0 -> exactly one write, one cycle after stall_in drops; cc=3'b010; retired +1 only.
- Wrap and reset mid-operation: preload retired=16'hFFFF via 65535 valid instructions, retire one more -> 0; assert reset_n=0 while valid=1 -> no write that cycle, state back to reset values.
